amuxbus_switch_sequencer: RTL and testbench
===========================================

# amuxbus_switch_sequencer

Digital sequencer that drives the analog mux switch enables connecting pads onto AMUXBUS_A / AMUXBUS_B in the padframe. Pads observe the buses; this block decides which pad owns each bus. Core-side requests arrive over a valid/ready handshake. Each switch change is executed break-before-make with a programmable settle time, so a bus never has two pads attached and a pad is never on both buses.

## Interface
Parameters:
- NPADS, 8: number of pads with amux switches; must be ≥ 2.
- PADW, $clog2(NPADS): width of the pad index.
- BREAK_CYC, 4: cycles the target bus is held fully open before make; must be ≥ 1.
- SETTLE_CYC, 16: cycles held after make before completion; must be ≥ 1.

Ports:
- axis_clk  in  1  clock; all logic on rising edge.
- axis_rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_bus  in  1  target bus: 0 = A, 1 = B.
- req_pad  in  PADW  pad index.
- req_connect  in  1  1 = connect the pad to the bus; 0 = open the bus.
- amux_a_en  out  NPADS  switch enables to AMUXBUS_A; one-hot or zero.
- amux_b_en  out  NPADS  switch enables to AMUXBUS_B; one-hot or zero.
- busy  out  1  high in any state except IDLE.
- done_pulse  out  1  one-cycle completion strobe, for both accepted and rejected requests.
- err  out  1  sticky error flag.
- err_clr  in  1  clears err.

## Operation
- States: IDLE, BREAK, SETTLE, DONE.
- req_ready = (state == IDLE) & axis_rst_n.
- A request is accepted on any edge where req_valid & req_ready are both high. Request fields are sampled only at acceptance.
- Rejection checks, evaluated at acceptance:
  - req_pad ≥ NPADS, or
  - req_connect = 1 and req_pad is currently enabled on the other bus.
- Rejected request: err is set, both enable vectors are unchanged, and the next state is DONE.
- Accepted valid request:
  - The target bus enable vector is cleared to all zeros. The other bus is untouched.
  - The state moves to BREAK, and the down-counter is loaded with BREAK_CYC−1.
- BREAK: count down. At zero:
  - if connect: set bit req_pad of the target vector, load the counter with SETTLE_CYC−1, and go to SETTLE;
  - otherwise go to DONE.
- SETTLE: count down. At zero, go to DONE.
- DONE: done_pulse = 1 for exactly this cycle, then IDLE.
- Reconnecting the pad that is already on the target bus is legal. It still opens the bus for BREAK_CYC cycles.
- Counter width is $clog2(max(BREAK_CYC, SETTLE_CYC)+1). It never wraps.
- err: set by a rejection, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Invariants, checked by assertions:
  - popcount(amux_a_en) ≤ 1 and popcount(amux_b_en) ≤ 1;
  - (amux_a_en & amux_b_en) == 0.
- Reset (at any point, including mid-sequence): state IDLE, counter 0, amux_a_en = 0, amux_b_en = 0, busy = 0, done_pulse = 0, err = 0. Requests presented during reset are ignored.

## Timing
- All outputs are registered except req_ready, which is decoded from the state register and axis_rst_n.
- Take the acceptance edge as E0.
- Enable vector after E0: target bus vector reads 0 from E0 onward.
- Make edge (connect only): the target bit rises at E0+BREAK_CYC.
- done_pulse:
  - connect: high in the cycle after edge E0+BREAK_CYC+SETTLE_CYC;
  - disconnect: high in the cycle after edge E0+BREAK_CYC;
  - rejection: high in the cycle after edge E0.
- req_ready returns high one edge after done_pulse. Back-to-back throughput is therefore BREAK_CYC+SETTLE_CYC+2 cycles per connect.
- The bus is open for at least BREAK_CYC full cycles between any two different pads being attached.

## Test plan
- Connect after reset, with defaults: pad 3 to bus A, accepted at E0. amux_a_en = 0x08 at E0+4. done_pulse in the cycle after E0+20. req_ready high again at E0+22.
- Swap: A holds pad 3; request pad 5 on A. amux_a_en reads 0x00 for cycles E0..E0+3 and 0x20 at E0+4. It is never 0x28.
- Cross-bus conflict: pad 5 is on A; request pad 5 on B. err goes to 1, amux_b_en is unchanged, done_pulse in the cycle after E0. err_clr then returns err to 0.
- Out of range: req_pad = 9 with NPADS = 8 and PADW = 4. The request is rejected, err = 1, and both vectors are unchanged.
- Disconnect bus B while pad 2 is attached: amux_b_en = 0 from E0. done_pulse in the cycle after E0+4. amux_a_en is unchanged throughout.
- Reset mid-SETTLE, with axis_rst_n low for 1 cycle: the next edge gives all enables 0, busy 0, err 0, and req_ready high once axis_rst_n returns high.

Source files
------------

// File: rtl/amuxbus_if.sv
// Request handshake and switch-enable bundle between the core and the amux sequencer.
interface amuxbus_if #(
  parameter int NPADS = 8,
  parameter int PADW  = $clog2(NPADS)
);
  logic             req_valid;
  logic             req_ready;
  logic             req_bus;
  logic [PADW-1:0]  req_pad;
  logic             req_connect;
  logic [NPADS-1:0] amux_a_en;
  logic [NPADS-1:0] amux_b_en;
  logic             busy;
  logic             done_pulse;
  logic             err;
  logic             err_clr;

  modport master (
    output req_valid, req_bus, req_pad, req_connect, err_clr,
    input  req_ready, amux_a_en, amux_b_en, busy, done_pulse, err
  );

  modport slave (
    input  req_valid, req_bus, req_pad, req_connect, err_clr,
    output req_ready, amux_a_en, amux_b_en, busy, done_pulse, err
  );
endinterface

// File: rtl/amuxbus_switch_sequencer.sv
// Break-before-make sequencer for the padframe AMUXBUS_A/AMUXBUS_B switch enables.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// BREAK  | target bus held fully open, counting down the break time
// SETTLE | new pad attached, counting down the settle time
// DONE   | one-cycle completion strobe, then back to IDLE
module amuxbus_switch_sequencer #(
  parameter int NPADS      = 8,
  parameter int PADW       = $clog2(NPADS),
  parameter int BREAK_CYC  = 4,
  parameter int SETTLE_CYC = 16
) (
  input logic      axis_clk,
  input logic      axis_rst_n,
  amuxbus_if.slave bus
);
  localparam int CNT_MAX = (BREAK_CYC > SETTLE_CYC) ? BREAK_CYC : SETTLE_CYC;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] BREAK_LOAD  = CNTW'(BREAK_CYC - 1);
  localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE_CYC - 1);
  localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);

  if (NPADS < 2) begin : g_chk_npads
    $error("NPADS must be at least 2");
  end
  if (BREAK_CYC < 1 || SETTLE_CYC < 1) begin : g_chk_cyc
    $error("BREAK_CYC and SETTLE_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BREAK  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [NPADS-1:0] a_en_q, a_en_d;
  logic [NPADS-1:0] b_en_q, b_en_d;
  logic             bus_q, bus_d;
  logic [PADW-1:0]  pad_q, pad_d;
  logic             conn_q, conn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             pad_in_range;
  logic             conflict;
  logic             reject;
  logic [NPADS-1:0] req_mask;
  logic [NPADS-1:0] other_en;

  // Out-of-range indices decode to an all-zero mask.
  function automatic logic [NPADS-1:0] pad_onehot(input logic [PADW-1:0] idx);
    logic [NPADS-1:0] m;
    m = '0;
    for (int i = 0; i < NPADS; i++) begin
      if (32'(idx) == i) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign bus.req_ready = (state_q == ST_IDLE) & axis_rst_n;

  assign accept       = bus.req_valid & bus.req_ready;
  assign pad_in_range = (32'(bus.req_pad) < NPADS);
  assign req_mask     = pad_onehot(bus.req_pad);
  assign other_en     = bus.req_bus ? a_en_q : b_en_q;
  assign conflict     = bus.req_connect & (|(req_mask & other_en));
  assign reject       = ~pad_in_range | conflict;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_en_d  = a_en_q;
    b_en_d  = b_en_q;
    bus_d   = bus_q;
    pad_d   = pad_q;
    conn_d  = conn_q;
    err_d   = err_q;

    if (bus.err_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (reject) begin
            // Set takes priority over a simultaneous clear.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            bus_d  = bus.req_bus;
            pad_d  = bus.req_pad;
            conn_d = bus.req_connect;
            if (bus.req_bus) b_en_d = '0;
            else             a_en_d = '0;
            cnt_d   = BREAK_LOAD;
            state_d = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        if (cnt_q == '0) begin
          if (conn_q) begin
            if (bus_q) b_en_d = pad_onehot(pad_q);
            else       a_en_d = pad_onehot(pad_q);
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_en_q  <= '0;
      b_en_q  <= '0;
      bus_q   <= 1'b0;
      pad_q   <= '0;
      conn_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_en_q  <= a_en_d;
      b_en_q  <= b_en_d;
      bus_q   <= bus_d;
      pad_q   <= pad_d;
      conn_q  <= conn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.amux_a_en  = a_en_q;
  assign bus.amux_b_en  = b_en_q;
  assign bus.busy       = busy_q;
  assign bus.done_pulse = done_q;
  assign bus.err        = err_q;

  // A bus never carries two pads and a pad never sits on both buses.
  a_onehot_a: assert property (@(posedge axis_clk) disable iff (!axis_rst_n) $onehot0(a_en_q));
  a_onehot_b: assert property (@(posedge axis_clk) disable iff (!axis_rst_n) $onehot0(b_en_q));
  a_disjoint: assert property (@(posedge axis_clk) disable iff (!axis_rst_n) (a_en_q & b_en_q) == '0);
endmodule

// File: tb/tb_amuxbus_switch_sequencer.sv
// Self-checking bench for amuxbus_switch_sequencer: directed table, hand sequences, random traffic.
module tb_amuxbus_switch_sequencer;
  localparam int NPADS = 8;
  localparam int PADW  = 4;
  localparam int BRK   = 4;
  localparam int STL   = 16;
  localparam int NTBL  = 14;

  logic axis_clk   = 1'b0;
  logic axis_rst_n = 1'b0;
  always #5 axis_clk = ~axis_clk;

  amuxbus_if #(.NPADS(NPADS), .PADW(PADW)) bus_if ();

  amuxbus_switch_sequencer #(
    .NPADS(NPADS), .PADW(PADW), .BREAK_CYC(BRK), .SETTLE_CYC(STL)
  ) dut (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .bus       (bus_if)
  );

  typedef struct {
    bit         rbus;
    int         pad;
    bit         conn;
    bit         clr_acc;
    bit         clr_after;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  vec_t tbl [NTBL];

  int total = 0;
  int bad   = 0;

  // Reference model: which pad owns each bus (-1 = open) and the error flag.
  int own_a = -1;
  int own_b = -1;
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  function automatic logic [7:0] vec_of(input int own);
    logic [7:0] v;
    v = '0;
    if (own >= 0) v[own] = 1'b1;
    return v;
  endfunction

  task automatic do_req(input bit rbus, input int pad, input bit conn, input bit clr_acc,
                        output int lat);
    int         tgt_old, oth, d, waited;
    bit         rej;
    logic [7:0] tgt_exp, tgt_act, oth_act;
    tgt_old = rbus ? own_b : own_a;
    oth     = rbus ? own_a : own_b;
    rej     = (pad >= NPADS) || (conn && pad == oth);
    d       = rej ? 0 : (conn ? BRK + STL : BRK);
    lat     = -1;

    bus_if.req_valid   = 1'b1;
    bus_if.req_bus     = rbus;
    bus_if.req_pad     = PADW'(pad);
    bus_if.req_connect = conn;
    bus_if.err_clr     = clr_acc;
    waited = 0;
    while (!bus_if.req_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!bus_if.req_ready) begin
      check("accept_timeout", 32'(bus_if.req_ready), 32'(1));
      bus_if.req_valid = 1'b0;
      bus_if.err_clr   = 1'b0;
      return;
    end
    tick();
    bus_if.req_valid   = 1'b0;
    bus_if.err_clr     = 1'b0;
    bus_if.req_bus     = 1'($urandom);
    bus_if.req_pad     = PADW'($urandom);
    bus_if.req_connect = 1'($urandom);

    if (rej) m_err = 1'b1;
    else if (clr_acc) m_err = 1'b0;

    for (int k = 0; k <= d + 1; k++) begin
      if (k > 0) tick();
      if (rej)                   tgt_exp = vec_of(tgt_old);
      else if (conn && k >= BRK) tgt_exp = vec_of(pad);
      else                       tgt_exp = '0;
      tgt_act = rbus ? bus_if.amux_b_en : bus_if.amux_a_en;
      oth_act = rbus ? bus_if.amux_a_en : bus_if.amux_b_en;
      check("target_en", 32'(tgt_act), 32'(tgt_exp));
      check("other_en", 32'(oth_act), 32'(vec_of(oth)));
      check("done_pulse", 32'(bus_if.done_pulse), 32'(k == d));
      check("busy", 32'(bus_if.busy), 32'(k <= d));
      check("req_ready", 32'(bus_if.req_ready), 32'(k == d + 1));
      check("err", 32'(bus_if.err), 32'(m_err));
      if (bus_if.done_pulse && lat < 0) lat = k;
    end

    if (!rej) begin
      if (rbus) own_b = conn ? pad : -1;
      else      own_a = conn ? pad : -1;
    end
  endtask

  task automatic pulse_clr();
    bus_if.err_clr = 1'b1;
    tick();
    bus_if.err_clr = 1'b0;
    m_err = 1'b0;
    check("err_clr", 32'(bus_if.err), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit rb, cn, ca;
    int pd;

    tbl[0]  = '{1'b0, 3,  1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 20};
    tbl[1]  = '{1'b0, 5,  1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 20};
    tbl[2]  = '{1'b1, 5,  1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b1, 0};
    tbl[3]  = '{1'b1, 9,  1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b1, 0};
    tbl[4]  = '{1'b1, 2,  1'b1, 1'b0, 1'b0, 8'h20, 8'h04, 1'b0, 20};
    tbl[5]  = '{1'b1, 2,  1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 4};
    tbl[6]  = '{1'b0, 5,  1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 20};
    tbl[7]  = '{1'b1, 12, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 0};
    tbl[8]  = '{1'b1, 6,  1'b1, 1'b1, 1'b0, 8'h20, 8'h40, 1'b0, 20};
    tbl[9]  = '{1'b0, 6,  1'b1, 1'b0, 1'b1, 8'h20, 8'h40, 1'b1, 0};
    tbl[10] = '{1'b0, 9,  1'b0, 1'b0, 1'b1, 8'h20, 8'h40, 1'b1, 0};
    tbl[11] = '{1'b0, 6,  1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 4};
    tbl[12] = '{1'b0, 1,  1'b1, 1'b0, 1'b0, 8'h02, 8'h40, 1'b0, 20};
    tbl[13] = '{1'b1, 1,  1'b1, 1'b0, 1'b0, 8'h02, 8'h40, 1'b1, 0};

    // Reset with a request presented: it must be ignored.
    bus_if.req_valid   = 1'b1;
    bus_if.req_bus     = 1'b0;
    bus_if.req_pad     = 4'd3;
    bus_if.req_connect = 1'b1;
    bus_if.err_clr     = 1'b0;
    axis_rst_n = 1'b0;
    repeat (3) tick();
    check("rst_a_en", 32'(bus_if.amux_a_en), 32'(0));
    check("rst_b_en", 32'(bus_if.amux_b_en), 32'(0));
    check("rst_busy", 32'(bus_if.busy), 32'(0));
    check("rst_done", 32'(bus_if.done_pulse), 32'(0));
    check("rst_err", 32'(bus_if.err), 32'(0));
    check("rst_ready_low", 32'(bus_if.req_ready), 32'(0));
    axis_rst_n       = 1'b1;
    bus_if.req_valid = 1'b0;
    #1;
    check("rst_ready_high", 32'(bus_if.req_ready), 32'(1));

    for (int i = 0; i < NTBL; i++) begin
      do_req(tbl[i].rbus, tbl[i].pad, tbl[i].conn, tbl[i].clr_acc, lat);
      check("tbl_lat", 32'(lat), 32'(tbl[i].exp_lat));
      check("tbl_a", 32'(bus_if.amux_a_en), 32'(tbl[i].exp_a));
      check("tbl_b", 32'(bus_if.amux_b_en), 32'(tbl[i].exp_b));
      check("tbl_err", 32'(bus_if.err), 32'(tbl[i].exp_err));
      if (tbl[i].clr_after) pulse_clr();
    end

    // Reset in the middle of SETTLE while err is set and a request is pending.
    bus_if.req_valid   = 1'b1;
    bus_if.req_bus     = 1'b0;
    bus_if.req_pad     = 4'd4;
    bus_if.req_connect = 1'b1;
    check("mid_ready", 32'(bus_if.req_ready), 32'(1));
    tick();
    bus_if.req_valid = 1'b0;
    repeat (BRK + 6) tick();
    check("mid_a_en", 32'(bus_if.amux_a_en), 32'(8'h10));
    check("mid_b_en", 32'(bus_if.amux_b_en), 32'(8'h40));
    check("mid_busy", 32'(bus_if.busy), 32'(1));
    check("mid_err", 32'(bus_if.err), 32'(1));
    axis_rst_n         = 1'b0;
    bus_if.req_valid   = 1'b1;
    bus_if.req_pad     = 4'd3;
    #1;
    check("mid_rst_ready", 32'(bus_if.req_ready), 32'(0));
    tick();
    check("mid_rst_a", 32'(bus_if.amux_a_en), 32'(0));
    check("mid_rst_b", 32'(bus_if.amux_b_en), 32'(0));
    check("mid_rst_busy", 32'(bus_if.busy), 32'(0));
    check("mid_rst_err", 32'(bus_if.err), 32'(0));
    check("mid_rst_done", 32'(bus_if.done_pulse), 32'(0));
    axis_rst_n       = 1'b1;
    bus_if.req_valid = 1'b0;
    #1;
    check("mid_rel_ready", 32'(bus_if.req_ready), 32'(1));
    tick();
    check("mid_idle_a", 32'(bus_if.amux_a_en), 32'(0));
    check("mid_idle_busy", 32'(bus_if.busy), 32'(0));
    own_a = -1;
    own_b = -1;
    m_err = 1'b0;

    for (int n = 0; n < 40; n++) begin
      rb = 1'($urandom_range(0, 1));
      pd = $urandom_range(0, 9);
      cn = ($urandom_range(0, 3) != 0);
      ca = ($urandom_range(0, 3) == 0);
      do_req(rb, pd, cn, ca, lat);
      if (m_err && $urandom_range(0, 2) == 0) pulse_clr();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
